attn_score_writer: RTL and testbench

- Receiving end of the attention-score stream from the spike-accumulation engine.
- Captures each head's score beats (`o_Calc_data`/`o_Calc_valid` on the producer side) into a ping-pong pair of score banks.
- Drives the producer's start-permission signal `i_AttnRAM_Ready`.
- Presents completed heads to the downstream Attn×V stage through a read port and a bank-release handshake.

---
 rtl/attn_score_writer_pkg.sv | 29 ++
 rtl/attn_score_writer_if.sv | 30 +++
 rtl/attn_score_bank_ram.sv | 40 ++++
 rtl/attn_score_writer.sv | 127 ++++++++++++
 tb/tb_attn_score_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/attn_score_writer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// attn_score_writer_pkg : shared hyper-parameters and bank/writer state types
// Revision: 1.0
// ---------------------------------------------------------------------------
package attn_score_writer_pkg;

  localparam int TIME_STEPS        = 4;
  localparam int SYSTOLIC_UNIT_NUM = 16;
  localparam int MULTI_HEAD_NUMS   = 12;
  localparam int SCORE_W           = $clog2(2 * SYSTOLIC_UNIT_NUM);
  localparam int BEATS_PER_HEAD    = 4096;
  localparam int ADDR_W            = $clog2(BEATS_PER_HEAD);
  localparam int DATA_W            = SCORE_W * TIME_STEPS;
  localparam int HEAD_W            = $clog2(MULTI_HEAD_NUMS);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/attn_score_writer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// attn_score_writer_if : producer score stream plus reader port and release
// Revision: 1.0
// ---------------------------------------------------------------------------
interface attn_score_writer_if;
  import attn_score_writer_pkg::*;

  logic [DATA_W-1:0] i_Calc_data;
  logic              i_Calc_valid;
  logic              o_AttnRAM_Ready;
  logic              o_head_valid;
  logic [HEAD_W-1:0] o_head_idx;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic              i_head_release;
  logic              o_overflow;

  modport master (
    output i_Calc_data, i_Calc_valid, i_rd_addr, i_head_release,
    input  o_AttnRAM_Ready, o_head_valid, o_head_idx, o_rd_data, o_overflow
  );

  modport slave (
    input  i_Calc_data, i_Calc_valid, i_rd_addr, i_head_release,
    output o_AttnRAM_Ready, o_head_valid, o_head_idx, o_rd_data, o_overflow
  );

endinterface
`default_nettype wire

// File: rtl/attn_score_bank_ram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// attn_score_bank_ram : simple dual-port RAM, registered read, BRAM-inferable
// Revision: 1.0
// ---------------------------------------------------------------------------
module attn_score_bank_ram #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
  end

  // Output-register reset maps onto the BRAM output latch reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[i_raddr];
    end
  end

  assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/attn_score_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// attn_score_writer : captures per-head score beats into ping-pong banks
// Revision: 1.0
// ---------------------------------------------------------------------------
module attn_score_writer (
  input logic                s_clk,
  input logic                s_rst,
  attn_score_writer_if.slave bus
);
  import attn_score_writer_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS_PER_HEAD - 1);
  localparam logic [HEAD_W-1:0] LAST_HEAD = HEAD_W'(MULTI_HEAD_NUMS - 1);

  wr_state_e         wr_state_q, wr_state_d;
  bank_state_e       bank_state_q [2];
  bank_state_e       bank_state_d [2];
  logic [HEAD_W-1:0] bank_tag_q [2];
  logic [HEAD_W-1:0] bank_tag_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [HEAD_W-1:0] wr_head_q, wr_head_d;
  logic              overflow_q, overflow_d;
  logic              ready_q, ready_d;
  logic              ram_we;
  logic [ADDR_W:0]   ram_waddr;
  logic              head_valid;

  assign head_valid = (bank_state_q[rd_ptr_q] == BANK_FULL);

  always_comb begin
    wr_state_d   = wr_state_q;
    bank_state_d = bank_state_q;
    bank_tag_d   = bank_tag_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    wr_head_d    = wr_head_q;
    overflow_d   = overflow_q;
    ram_we       = 1'b0;
    ram_waddr    = {wr_ptr_q, beat_cnt_q};

    // Release is applied first so the writer sees a just-freed bank as EMPTY.
    if (bus.i_head_release && head_valid) begin
      bank_state_d[rd_ptr_q] = BANK_EMPTY;
      rd_ptr_d               = ~rd_ptr_q;
    end

    if (bus.i_Calc_valid) begin
      unique case (wr_state_q)
        WR_IDLE: begin
          if (bank_state_d[wr_ptr_q] == BANK_EMPTY) begin
            bank_state_d[wr_ptr_q] = BANK_FILLING;
            ram_we                 = 1'b1;
            ram_waddr              = {wr_ptr_q, {ADDR_W{1'b0}}};
            beat_cnt_d             = ADDR_W'(1);
            wr_state_d             = WR_WRITE;
          end else begin
            overflow_d = 1'b1;
          end
        end
        WR_WRITE: begin
          ram_we = 1'b1;
          if (beat_cnt_q == LAST_BEAT) begin
            bank_state_d[wr_ptr_q] = BANK_FULL;
            bank_tag_d[wr_ptr_q]   = wr_head_q;
            wr_head_d              = (wr_head_q == LAST_HEAD) ? '0 : wr_head_q + 1'b1;
            wr_ptr_d               = ~wr_ptr_q;
            beat_cnt_d             = '0;
            wr_state_d             = WR_IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end

    ready_d = (bank_state_d[0] == BANK_EMPTY) || (bank_state_d[1] == BANK_EMPTY);
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      wr_state_q   <= WR_IDLE;
      bank_state_q <= '{BANK_EMPTY, BANK_EMPTY};
      bank_tag_q   <= '{'0, '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      beat_cnt_q   <= '0;
      wr_head_q    <= '0;
      overflow_q   <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      wr_state_q   <= wr_state_d;
      bank_state_q <= bank_state_d;
      bank_tag_q   <= bank_tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      wr_head_q    <= wr_head_d;
      overflow_q   <= overflow_d;
      ready_q      <= ready_d;
    end
  end

  attn_score_bank_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W + 1)
  ) u_bank_ram (
    .clk     (s_clk),
    .rst     (s_rst),
    .i_we    (ram_we),
    .i_waddr (ram_waddr),
    .i_wdata (bus.i_Calc_data),
    .i_raddr ({rd_ptr_q, bus.i_rd_addr}),
    .o_rdata (bus.o_rd_data)
  );

  assign bus.o_AttnRAM_Ready = ready_q;
  assign bus.o_head_valid    = head_valid;
  assign bus.o_head_idx      = bank_tag_q[rd_ptr_q];
  assign bus.o_overflow      = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_attn_score_writer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_attn_score_writer : randomized stimulus against a head-queue reference
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_attn_score_writer;
  import attn_score_writer_pkg::*;

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;

  attn_score_writer_if bus ();

  attn_score_writer u_dut (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .bus   (bus.slave)
  );

  always #5 s_clk = ~s_clk;

  int checks = 0;
  int errors = 0;

  // Reference: completed heads waiting for the reader, oldest first.
  int              fq_idx  [$];
  int unsigned     fq_salt [$];
  bit              m_filling   = 0;
  int              m_cnt       = 0;
  int              m_head_ctr  = 0;
  int unsigned     m_part_salt = 0;
  bit              m_ovf       = 0;
  bit              m_ready     = 0;
  bit              m_rd_chk    = 0;
  logic [DATA_W-1:0] m_rd_exp  = '0;
  bit              model_live  = 0;

  int unsigned       cur_salt   = 0;
  bit                force_en   = 0;
  logic [ADDR_W-1:0] force_addr = '0;

  // Beat payload; salt 0 yields the plain beat index.
  function automatic logic [DATA_W-1:0] bd(int unsigned salt, int addr);
    logic [31:0] h;
    if (salt == 0) h = 32'(addr);
    else           h = (32'(addr) * 32'h9E3779B1) ^ (salt * 32'h85EBCA6B) ^ (salt >> 11);
    return h[DATA_W-1:0];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge s_clk);
      model_live = 1;
      if (s_rst) begin
        fq_idx.delete();
        fq_salt.delete();
        m_filling  = 0;
        m_cnt      = 0;
        m_head_ctr = 0;
        m_ovf      = 0;
        m_ready    = 0;
        m_rd_chk   = 1;
        m_rd_exp   = '0;
      end else begin
        m_rd_chk = (fq_idx.size() > 0);
        if (m_rd_chk) m_rd_exp = bd(fq_salt[0], int'(bus.i_rd_addr));
        if (bus.i_head_release && fq_idx.size() > 0) begin
          void'(fq_idx.pop_front());
          void'(fq_salt.pop_front());
        end
        if (bus.i_Calc_valid) begin
          if (!m_filling) begin
            if (fq_idx.size() < 2) begin
              m_filling   = 1;
              m_cnt       = 1;
              m_part_salt = cur_salt;
            end else begin
              m_ovf = 1;
            end
          end else begin
            m_cnt++;
            if (m_cnt == BEATS_PER_HEAD) begin
              fq_idx.push_back(m_head_ctr);
              fq_salt.push_back(m_part_salt);
              m_head_ctr = (m_head_ctr + 1) % MULTI_HEAD_NUMS;
              m_filling  = 0;
              m_cnt      = 0;
            end
          end
        end
        m_ready = (fq_idx.size() + int'(m_filling)) < 2;
      end
    end
  end

  initial begin
    forever begin
      @(negedge s_clk);
      if (model_live) begin
        chk("ready", 32'(bus.o_AttnRAM_Ready), 32'(m_ready));
        chk("head_valid", 32'(bus.o_head_valid), 32'(fq_idx.size() > 0));
        if (fq_idx.size() > 0) chk("head_idx", 32'(bus.o_head_idx), fq_idx[0]);
        chk("overflow", 32'(bus.o_overflow), 32'(m_ovf));
        if (m_rd_chk) chk("rd_data", 32'(bus.o_rd_data), 32'(m_rd_exp));
      end
    end
  end

  task automatic tick();
    @(posedge s_clk);
    #1;
    bus.i_Calc_valid   = 1'b0;
    bus.i_head_release = 1'b0;
    bus.i_rd_addr      = force_en ? force_addr : ADDR_W'($urandom);
  endtask

  task automatic send_beats(int unsigned salt, int first, int count, int rel_at);
    cur_salt = salt;
    for (int i = first; i < first + count; i++) begin
      if ($urandom_range(15) == 0) tick();
      bus.i_Calc_valid   = 1'b1;
      bus.i_Calc_data    = bd(salt, i);
      bus.i_head_release = (i == rel_at);
      tick();
    end
  endtask

  task automatic read_chk(string name, int addr, logic [DATA_W-1:0] exp);
    force_en      = 1;
    force_addr    = ADDR_W'(addr);
    bus.i_rd_addr = ADDR_W'(addr);
    tick();
    chk(name, 32'(bus.o_rd_data), 32'(exp));
    force_en = 0;
  endtask

  task automatic release_head();
    bus.i_head_release = 1'b1;
    tick();
  endtask

  initial begin
    int unsigned s;
    bus.i_Calc_valid   = 1'b0;
    bus.i_Calc_data    = '0;
    bus.i_head_release = 1'b0;
    bus.i_rd_addr      = '0;

    s_rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(bus.o_AttnRAM_Ready), 0);
    chk("rst_valid", 32'(bus.o_head_valid), 0);
    chk("rst_idx", 32'(bus.o_head_idx), 0);
    chk("rst_rd_data", 32'(bus.o_rd_data), 0);
    chk("rst_overflow", 32'(bus.o_overflow), 0);
    s_rst = 1'b0;
    tick();
    chk("ready_after_rst", 32'(bus.o_AttnRAM_Ready), 1);

    // Head 0 with index data, then fixed-address reads.
    send_beats(0, 0, BEATS_PER_HEAD, -1);
    chk("h0_valid", 32'(bus.o_head_valid), 1);
    chk("h0_idx", 32'(bus.o_head_idx), 0);
    chk("h0_ready", 32'(bus.o_AttnRAM_Ready), 1);
    read_chk("rd_0", 0, 0);
    read_chk("rd_100", 100, 100);
    read_chk("rd_4095", 4095, 4095);

    // Second head with no release: both banks full.
    s = $urandom | 1;
    send_beats(s, 0, BEATS_PER_HEAD, -1);
    chk("both_full_ready", 32'(bus.o_AttnRAM_Ready), 0);
    chk("both_full_idx", 32'(bus.o_head_idx), 0);

    // Beat with nowhere to go.
    bus.i_Calc_valid = 1'b1;
    bus.i_Calc_data  = DATA_W'($urandom);
    tick();
    chk("ovf_set", 32'(bus.o_overflow), 1);
    read_chk("ovf_rd_0", 0, 0);
    repeat (3) tick();
    chk("ovf_sticky", 32'(bus.o_overflow), 1);
    release_head();
    chk("rel_idx", 32'(bus.o_head_idx), 1);
    chk("rel_ready", 32'(bus.o_AttnRAM_Ready), 1);
    read_chk("rel_rd_0", 0, bd(s, 0));

    // Head 2 fills the freed bank; head 3 starts on the cycle head 1 is released.
    send_beats($urandom | 1, 0, BEATS_PER_HEAD, -1);
    chk("h2_ready", 32'(bus.o_AttnRAM_Ready), 0);
    s = $urandom | 1;
    send_beats(s, 0, 1, 0);
    chk("rel_first_idx", 32'(bus.o_head_idx), 2);
    chk("rel_first_ready", 32'(bus.o_AttnRAM_Ready), 0);
    send_beats(s, 1, BEATS_PER_HEAD - 1, BEATS_PER_HEAD - 1);
    chk("rel_last_valid", 32'(bus.o_head_valid), 1);
    chk("rel_last_idx", 32'(bus.o_head_idx), 3);
    release_head();
    chk("drain_valid", 32'(bus.o_head_valid), 0);
    release_head();
    chk("idle_rel_valid", 32'(bus.o_head_valid), 0);
    chk("idle_rel_ready", 32'(bus.o_AttnRAM_Ready), 1);

    // Heads 4..11 and the wrap back to tag 0, releasing mid-fill.
    for (int k = 4; k <= MULTI_HEAD_NUMS; k++) begin
      send_beats($urandom | 1, 0, BEATS_PER_HEAD, (k == 4) ? -1 : int'($urandom_range(0, BEATS_PER_HEAD - 1)));
      chk("seq_idx", 32'(bus.o_head_idx), k % MULTI_HEAD_NUMS);
    end
    release_head();

    // Reset in the middle of a head.
    send_beats($urandom | 1, 0, 2000, -1);
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    chk("mid_rst_ready", 32'(bus.o_AttnRAM_Ready), 0);
    chk("mid_rst_valid", 32'(bus.o_head_valid), 0);
    chk("mid_rst_idx", 32'(bus.o_head_idx), 0);
    chk("mid_rst_rd", 32'(bus.o_rd_data), 0);
    chk("mid_rst_ovf", 32'(bus.o_overflow), 0);
    tick();
    chk("mid_rst_ready1", 32'(bus.o_AttnRAM_Ready), 1);
    send_beats(0, 0, BEATS_PER_HEAD, -1);
    chk("post_rst_idx", 32'(bus.o_head_idx), 0);
    chk("post_rst_valid", 32'(bus.o_head_valid), 1);
    read_chk("post_rst_rd_0", 0, 0);
    read_chk("post_rst_rd_1999", 1999, 1999);
    read_chk("post_rst_rd_4095", 4095, 4095);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("FAIL watchdog: actual=timeout expected=completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
